// File: rtl/dot_pkg.sv
// Shared sizing and sequencer state encoding for the dot-product datapath.
package dot_pkg;

  localparam int unsigned N_ELEM = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned VCNT_W = 16;
  localparam int unsigned IDX_W  = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/dot_result_slot.sv
// One-entry valid/ready result register with a wrapping count of captures.
module dot_result_slot
  import dot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [RES_W-1:0]  capture_data,
  input  logic              res_ready,
  output logic              free_c,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  output logic [VCNT_W-1:0] vec_count
);

  // Slot can take a new result if empty or being drained this cycle.
  assign free_c = !res_valid || res_ready;

  // Capture wins over drain, so a same-cycle drain and capture stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      vec_count <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= capture_data;
        vec_count <= vec_count + VCNT_W'(1);
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dot_vec_sequencer.sv
// Collects operand pairs into a bank, starts the accelerator and captures its result.
module dot_vec_sequencer
  import dot_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     acc_start,
  input  logic                     acc_done,
  output logic [N_ELEM*DATA_W-1:0] acc_a,
  output logic [N_ELEM*DATA_W-1:0] acc_b,
  input  logic [RES_W-1:0]         acc_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_W-1:0]         res_data,
  output logic [VCNT_W-1:0]        vec_count
);

  localparam logic [1:0] S_FILL      = 2'(FILL);
  localparam logic [1:0] S_START     = 2'(START);
  localparam logic [1:0] S_WAIT_LOW  = 2'(WAIT_LOW);
  localparam logic [1:0] S_WAIT_HIGH = 2'(WAIT_HIGH);

  logic [1:0]       state_q;
  logic [1:0]       state_n;
  logic [IDX_W-1:0] idx_q;
  logic             beat_c;
  logic             last_beat_c;
  logic             capture_c;
  logic             slot_free_c;

  assign beat_c      = in_valid && in_ready;
  assign last_beat_c = beat_c && (idx_q == IDX_W'(N_ELEM - 1));
  assign capture_c   = (state_q == S_WAIT_HIGH) && acc_done && slot_free_c;

  // Next-state logic; WAIT_LOW skips the done level left over from the last run.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_FILL:      if (last_beat_c) state_n = S_START;
      S_START:     state_n = S_WAIT_LOW;
      S_WAIT_LOW:  if (!acc_done) state_n = S_WAIT_HIGH;
      S_WAIT_HIGH: if (capture_c) state_n = S_FILL;
      default:     state_n = S_FILL;
    endcase
  end

  // State register; in_ready and acc_start are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      in_ready  <= 1'b0;
      acc_start <= 1'b0;
    end else begin
      state_q   <= state_n;
      in_ready  <= (state_n == S_FILL);
      acc_start <= (state_n == S_START);
    end
  end

  // Operand bank; only written by accepted beats, so it holds from START to capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_a <= '0;
      acc_b <= '0;
    end else if (beat_c) begin
      for (int i = 0; i < int'(N_ELEM); i++) begin
        if (idx_q == IDX_W'(i)) begin
          acc_a[i*DATA_W +: DATA_W] <= in_a;
          acc_b[i*DATA_W +: DATA_W] <= in_b;
        end
      end
      idx_q <= last_beat_c ? '0 : idx_q + IDX_W'(1);
    end
  end

  dot_result_slot u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture_c),
    .capture_data (acc_result),
    .res_ready    (res_ready),
    .free_c       (slot_free_c),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .vec_count    (vec_count)
  );

endmodule
